// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressable data memory controller:
// access-size encodings, controller state type and the byte-lane mask helper.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    // Byte-lane write mask for a 32-bit word. A 16-bit build uses the low two
    // bits of the result; its lane is a single bit, so lane[1] is always 0
    // there and a half access selects lanes 1:0.
    // A half ignores lane[0] and a word ignores the lane entirely, which gives
    // the truncating behaviour for misaligned addresses.
    function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] lane);
        logic [3:0] m;
        m = 4'b1111;
        case (size)
            SZ_BYTE: m = 4'b0001 << lane;
            SZ_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between the MEM stage (master) and dmem_ctrl (slave).
// align_err exists only when DMEM_ALIGN_CHECK_EN is defined.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// The master holds req_* stable while req_valid=1 and req_ready=0. req_ready
// stays high once the clear sweep is done, so every cycle can carry a request.
// rsp_valid is a one-cycle pulse, one cycle after each accepted load, with no
// back-pressure; rsp_rdata holds its last value while rsp_valid=0.
interface dmem_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              init_done;
`ifdef DMEM_ALIGN_CHECK_EN
    logic              align_err;
`endif

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, init_done
`ifdef DMEM_ALIGN_CHECK_EN
        , align_err
`endif
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, init_done
`ifdef DMEM_ALIGN_CHECK_EN
        , align_err
`endif
    );

endinterface

// File: rtl/dmem_load_ext.sv
// Registered load-data stage: pick the addressed byte or half out of the raw
// word, shift it to bit 0 and sign- or zero-extend it. The register updates
// only when a load is accepted, so the output holds between responses.
module dmem_load_ext
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_zero,
    input  logic [DATA_W-1:0] i_raw,
    input  logic [1:0]        i_size,
    input  logic [LANE_W-1:0] i_lane,
    input  logic              i_signed,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] w_shift;
    logic [7:0]        w_byte;
    logic              w_hsel;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_ext;
    logic [DATA_W-1:0] r_rdata;

    // Lane extraction and extension; a half in a 16-bit build is the whole word.
    always_comb begin
        w_shift = i_raw >> {i_lane, 3'b000};
        w_byte  = w_shift[7:0];
        w_hsel  = (DATA_W == 32) ? i_lane[LANE_W-1] : 1'b0;
        w_half  = w_hsel ? i_raw[DATA_W-1 -: 16] : i_raw[15:0];
        w_ext   = i_raw;
        case (i_size)
            SZ_BYTE: begin
                w_ext       = {DATA_W{i_signed & w_byte[7]}};
                w_ext[7:0]  = w_byte;
            end
            SZ_HALF: begin
                w_ext       = {DATA_W{i_signed & w_half[15]}};
                w_ext[15:0] = w_half;
            end
            default: w_ext = i_raw;
        endcase
    end

    // Response data register, loaded only on an accepted load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_en) begin
            r_rdata <= i_zero ? '0 : w_ext;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressable data memory for the MEM stage. After reset a hardware sweep
// zeroes every word (CLEAR), then requests are taken one per cycle (RUN).
// Stores commit on the accepting edge with byte-lane enables; loads answer one
// cycle later through dmem_load_ext. Out-of-range stores are dropped and
// out-of-range loads return zero.
// Build option: DMEM_ALIGN_CHECK_EN turns misaligned accesses into suppressed
// stores / zero loads with an align_err pulse; without it the offending low
// address bits are simply ignored.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 16384
) (
    input  logic         clk,
    input  logic         rst_n,
    dmem_ctrl_if.slave   bus,
    output state_t       o_dbg_state
);

    localparam int BYTES  = DATA_W / 8;
    localparam int LANE_W = $clog2(BYTES);
    localparam int IDX_W  = ADDR_W - LANE_W;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W:0]    DEPTH_V  = (IDX_W + 1)'(DEPTH);
    localparam logic [MEM_AW-1:0] LAST_IDX = MEM_AW'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            r_state;
    state_t            w_state_nxt;
    logic [MEM_AW-1:0] r_clr_cnt;
    logic              r_rsp_valid;

    logic              w_ready;
    logic              w_accept;
    logic              w_load;
    logic              w_store;
    logic [IDX_W-1:0]  w_widx;
    logic [MEM_AW-1:0] w_mem_idx;
    logic [LANE_W-1:0] w_lane;
    logic [1:0]        w_size_eff;
    logic              w_in_range;
    logic              w_misal;
    logic [3:0]        w_mask4;
    logic [BYTES-1:0]  w_mask;
    logic [DATA_W-1:0] w_store_data;

    logic              w_we;
    logic [MEM_AW-1:0] w_wr_idx;
    logic [BYTES-1:0]  w_wr_mask;
    logic [DATA_W-1:0] w_wr_data;
    logic [DATA_W-1:0] w_raw;
    logic [DATA_W-1:0] w_rdata;

    assign w_ready  = (r_state == ST_RUN);
    assign w_accept = bus.req_valid && w_ready;
    assign w_load   = w_accept && !bus.req_write;
    assign w_store  = w_accept && bus.req_write;

    assign w_widx     = bus.req_addr[ADDR_W-1:LANE_W];
    assign w_lane     = bus.req_addr[LANE_W-1:0];
    assign w_mem_idx  = w_widx[MEM_AW-1:0];
    assign w_in_range = ({1'b0, w_widx} < DEPTH_V);

    // Size normalisation: reserved code 3 is a word; a 16-bit word is a half.
    always_comb begin
        w_size_eff = bus.req_size;
        if (DATA_W == 16 && bus.req_size[1]) begin
            w_size_eff = SZ_HALF;
        end else if (bus.req_size == 2'd3) begin
            w_size_eff = SZ_WORD;
        end
    end

    // Misalignment detection (only meaningful with the alignment check built in).
    always_comb begin
`ifdef DMEM_ALIGN_CHECK_EN
        w_misal = ((w_size_eff == SZ_HALF) && w_lane[0]) ||
                  ((w_size_eff == SZ_WORD) && (w_lane != '0));
`else
        w_misal = 1'b0;
`endif
    end

    // Store lane mask and store data replicated into every lane position.
    always_comb begin
        w_mask4      = lane_mask(w_size_eff, 2'(w_lane));
        w_mask       = w_mask4[BYTES-1:0];
        w_store_data = bus.req_wdata;
        case (w_size_eff)
            SZ_BYTE: w_store_data = {BYTES{bus.req_wdata[7:0]}};
            SZ_HALF: w_store_data = {(BYTES / 2){bus.req_wdata[15:0]}};
            default: w_store_data = bus.req_wdata;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and memory write-port selection: sweep writes in CLEAR,
    // accepted in-range aligned stores in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_wr_idx    = w_mem_idx;
        w_wr_mask   = '0;
        w_wr_data   = '0;
        case (r_state)
            ST_CLEAR: begin
                w_we      = 1'b1;
                w_wr_idx  = r_clr_cnt;
                w_wr_mask = '1;
                w_wr_data = '0;
                if (r_clr_cnt == LAST_IDX) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_store && w_in_range && !w_misal) begin
                    w_we      = 1'b1;
                    w_wr_idx  = w_mem_idx;
                    w_wr_mask = w_mask;
                    w_wr_data = w_store_data;
                end
            end
            default: w_state_nxt = ST_CLEAR;
        endcase
    end

    // Clear-sweep word counter; restarts from word 0 on every reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    // Memory array write with per-byte lane enables (array itself is not reset).
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_wr_mask[b]) begin
                    mem[w_wr_idx][b*8 +: 8] <= w_wr_data[b*8 +: 8];
                end
            end
        end
    end

    assign w_raw = mem[w_mem_idx];

    // Load response valid pulse, one cycle after each accepted load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
        end else begin
            r_rsp_valid <= w_load;
        end
    end

    dmem_load_ext #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_load_ext (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (w_load),
        .i_zero   (!w_in_range || w_misal),
        .i_raw    (w_raw),
        .i_size   (w_size_eff),
        .i_lane   (w_lane),
        .i_signed (bus.req_signed),
        .o_rdata  (w_rdata)
    );

`ifdef DMEM_ALIGN_CHECK_EN
    logic r_align_err;

    // Misalignment pulse, one cycle after the offending request is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_align_err <= 1'b0;
        end else begin
            r_align_err <= w_accept && w_misal;
        end
    end

    assign bus.align_err = r_align_err;
`endif

    assign bus.req_ready = w_ready;
    assign bus.init_done = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = w_rdata;
    assign o_dbg_state   = r_state;

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised byte-addressable data memory for the MIPS datapath MEM stage, replacing the fixed 16-bit word-only memory. Supports byte, half and word loads and stores with byte-lane write enables, and sign or zero extension on loads. Uses a valid/ready request channel and a registered one-cycle read response. A hardware clear sweep after reset zeroes the array.

Parameters:
DATA_W, 32, word width in bits; legal values 16 or 32; BYTES = DATA_W/8.
ADDR_W, 16, byte-address width.
DEPTH, 16384, number of words; must satisfy DEPTH <= 2**(ADDR_W - log2(BYTES)).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word).
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  store data, right-justified.
rsp_valid  out  1  load data valid, one-cycle pulse per accepted load.
rsp_rdata  out  DATA_W  extended load data.
init_done  out  1  clear sweep complete.
align_err  out  1  misalignment pulse; present only with DMEM_ALIGN_CHECK_EN.

Behaviour:
- Reset (asynchronous, rst_n=0): req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, align_err=0, clear counter=0, state=CLEAR. Reset asserted mid-sweep or mid-read aborts the operation; the sweep restarts from word 0 after release.
- CLEAR state: writes zero to word clr_cnt each cycle and increments clr_cnt. After word DEPTH-1 is written, moves to RUN and sets init_done=1 and req_ready=1. req_ready rises exactly DEPTH cycles after rst_n deasserts. Requests presented during CLEAR are ignored, since req_ready=0.
- RUN state: req_ready is held at 1, giving one request per cycle with no stalls. A request is accepted when req_valid && req_ready.
- Address decode: word index = req_addr >> log2(BYTES); lane = req_addr[log2(BYTES)-1:0].
- Store: commits on the accepting edge.
  - Byte: writes lane `lane` with req_wdata[7:0].
  - Half: writes the lane pair selected by req_addr[1] with req_wdata[15:0].
  - Word: writes all lanes.
  - A store produces no response.
- Load: rsp_valid=1 on the cycle after acceptance. rsp_rdata holds the selected byte or half shifted to bit 0, then sign- or zero-extended to DATA_W. A word load returns the full word and ignores req_signed.
- Back-to-back loads produce back-to-back rsp_valid pulses.
- rsp_rdata holds its last value when rsp_valid=0.
- A load accepted the cycle after a store to the same word returns the updated data.
- When DATA_W=16, req_size 2 and 3 behave as half.
- Out of range (word index >= DEPTH): a store is dropped; a load returns rsp_valid=1 with rsp_rdata=0.
- Misalignment, default build: the offending low address bits are ignored. A half ignores addr[0]; a word ignores all lane bits.

Optional Feature:
DMEM_ALIGN_CHECK_EN
- Defined: a half access with addr[0]=1, or a word access with any lane bit set, is misaligned.
  - A misaligned store is suppressed.
  - A misaligned load returns rsp_valid=1 with rsp_rdata=0.
  - align_err pulses high for one cycle, on the cycle after acceptance, for both loads and stores.
- Undefined: the align_err port and its logic are absent, and the truncation rule above applies.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2;
  - state enum {ST_CLEAR, ST_RUN};
  - a function computing the byte-lane enable mask from size and lane.
- Sub-module dmem_load_ext: the registered-output lane extract and extend stage. Inputs are the raw word, size, lane and signed; output is rsp_rdata.

Test Plan:
- DEPTH=16 reset: release rst_n -> req_ready and init_done go high exactly 16 cycles later; every word read after that returns 0.
- Store word 0xDEADBEEF at 0x0004, then load word at 0x0004 the next cycle -> rsp_valid one cycle after acceptance, rsp_rdata=0xDEADBEEF.
- Loads after that store:
  - signed byte load at 0x0004 -> 0xFFFFFFEF;
  - unsigned byte load at 0x0007 -> 0x000000DE;
  - signed half load at 0x0006 -> 0xFFFFDEAD.
- Store byte 0x55 to 0x0005 over 0xDEADBEEF -> word load at 0x0004 returns 0xDEAD55EF; other lanes unchanged.
- Assert rst_n=0 during a load response and midway through CLEAR -> rsp_valid drops immediately; the sweep restarts and takes the full DEPTH cycles again.
- With DMEM_ALIGN_CHECK_EN, store word to 0x0006 -> memory unchanged, align_err pulses once. Without the macro, the same store writes word index 1.
